// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART constants and receiver state encoding (uart_tx uses the same divisor default).
package uart_rx_pkg;

    localparam int UART_DATA_BITS        = 8;
    localparam int UART_BAUD_DIV_DEFAULT = 104;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line plus byte valid/ready port; parity_err exists only with UART_RX_PARITY_EN.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic                      rx;
    logic [UART_DATA_BITS-1:0] data;
    logic                      valid;
    logic                      ready;
    logic                      frame_err;
    logic                      overrun;
    logic                      busy;
`ifdef UART_RX_PARITY_EN
    logic                      parity_err;

    modport master (input rx, input ready,
                    output data, output valid, output frame_err, output overrun, output busy,
                    output parity_err);
    modport slave  (output rx, output ready,
                    input data, input valid, input frame_err, input overrun, input busy,
                    input parity_err);
`else
    modport master (input rx, input ready,
                    output data, output valid, output frame_err, output overrun, output busy);
    modport slave  (output rx, output ready,
                    input data, input valid, input frame_err, input overrun, input busy);
`endif

endinterface

// File: rtl/uart_rx_sync2.sv
// rtl/uart_rx_sync2.sv - two-flop synchronizer for asynchronous pad inputs with selectable reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ff <= {2{RST_VAL}};
        else     r_ff <= {r_ff[0], i_d};
    end

    assign o_q = r_ff[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 oversampling UART receiver with valid/ready byte delivery; UART_RX_PARITY_EN selects 8E1.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD_DIV  = UART_BAUD_DIV_DEFAULT,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);

    localparam int                CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

    rx_state_e              r_state, w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [2:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   w_rx_s;
    logic                   w_tick;
    logic                   w_load_half;
    logic                   w_shift;
    logic                   w_complete;
    logic                   w_ferr;
`ifdef UART_RX_PARITY_EN
    logic                   r_par_bad;
    logic                   r_parity_err;
    logic                   w_par_sample;
`endif

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.rx),
        .o_q (w_rx_s)
    );

    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_load_half = 1'b0;
        w_shift     = 1'b0;
        w_complete  = 1'b0;
        w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_rx_s) begin
                    w_next      = ST_START;
                    w_load_half = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) w_next = w_rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift = 1'b1;
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_next = ST_PARITY;
`else
                        w_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_par_sample = 1'b1;
                    w_next       = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
                        w_complete = !r_par_bad;
`else
                        w_complete = 1'b1;
`endif
                        w_next = ST_IDLE;
                    end else begin
                        w_ferr = 1'b1;
                        w_next = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (w_rx_s) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Start is sampled half a bit in, so every later tick lands mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_load_half)           r_cnt <= CNT_HALF;
            else if (r_state != ST_IDLE) r_cnt <= w_tick ? CNT_FULL : r_cnt - CNT_W'(1);
            if (r_state == ST_START)   r_bit_idx <= '0;
            else if (w_shift)          r_bit_idx <= r_bit_idx + 3'd1;
            if (w_shift)               r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_par_sample & (w_rx_s ^ (^r_shift));
            if (r_state == ST_START) r_par_bad <= 1'b0;
            else if (w_par_sample)   r_par_bad <= w_rx_s ^ (^r_shift);
        end
    end

    assign bus.parity_err = r_parity_err;
`endif

    // A held, unaccepted byte always wins over a newly completed one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= w_complete & r_valid & !bus.ready;
            if (w_complete && (!r_valid || bus.ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && bus.ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - table-driven and sequence checks for uart_rx at BAUD_DIV=16.
module tb_uart_rx;

    localparam int BD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if u_if ();

    uart_rx #(.BAUD_DIV(BD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid_cyc = 0, n_ferr = 0, n_ovr = 0, n_busy = 0, n_hold_viol = 0;
`ifdef UART_RX_PARITY_EN
    int   n_perr   = 0;
    logic par_flip = 1'b0;
`endif
    logic [7:0] acc_q[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.valid)                acc_q.size();
            if (u_if.valid)                n_valid_cyc++;
            if (u_if.valid && u_if.ready)  acc_q.push_back(u_if.data);
            if (u_if.frame_err)            n_ferr++;
            if (u_if.overrun)              n_ovr++;
            if (u_if.busy)                 n_busy++;
`ifdef UART_RX_PARITY_EN
            if (u_if.parity_err)           n_perr++;
`endif
            if (prev_hold && u_if.valid && u_if.data != prev_data) n_hold_viol++;
        end
        prev_hold = u_if.valid && !u_if.ready;
        prev_data = u_if.data;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int last_byte();
        if (acc_q.size() == 0) return -1;
        return int'(acc_q[acc_q.size()-1]);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        u_if.rx = b;
        cyc(BD);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_b);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop_b;
        int         exp_n;
        logic [7:0] exp_d;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];
    int   b_q, b_v, b_f, b_o, b_b;

    task automatic snap();
        b_q = acc_q.size(); b_v = n_valid_cyc; b_f = n_ferr; b_o = n_ovr; b_b = n_busy;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[3] = '{8'h3C, 1'b0, 0, 8'h00, 1};
        vecs[4] = '{8'h81, 1'b1, 1, 8'h81, 0};

        u_if.rx    = 1'b1;
        u_if.ready = 1'b0;
        cyc(3);
        check("reset_data",  int'(u_if.data), 0);
        check("reset_valid", int'(u_if.valid), 0);
        check("reset_ferr",  int'(u_if.frame_err), 0);
        check("reset_ovr",   int'(u_if.overrun), 0);
        check("reset_busy",  int'(u_if.busy), 0);
        rst = 1'b0;
        cyc(5);

        u_if.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            snap();
            send_frame(vecs[i].d, vecs[i].stop_b);
            u_if.rx = 1'b1;
            cyc(2 * BD);
            check($sformatf("vec%0d_bytes", i), acc_q.size() - b_q, vecs[i].exp_n);
            check($sformatf("vec%0d_valid_cycles", i), n_valid_cyc - b_v, vecs[i].exp_n);
            check($sformatf("vec%0d_ferr", i), n_ferr - b_f, vecs[i].exp_ferr);
            check($sformatf("vec%0d_ovr", i), n_ovr - b_o, 0);
            if (vecs[i].exp_n > 0) check($sformatf("vec%0d_data", i), last_byte(), int'(vecs[i].exp_d));
        end

        // overrun: two frames with no consumer
        u_if.ready = 1'b0;
        snap();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        u_if.rx = 1'b1;
        cyc(2 * BD);
        check("ovr_valid_held", int'(u_if.valid), 1);
        check("ovr_data_held",  int'(u_if.data), 8'h00);
        check("ovr_pulses",     n_ovr - b_o, 1);
        u_if.ready = 1'b1;
        cyc(1);
        check("ovr_valid_drop", int'(u_if.valid), 0);
        cyc(2 * BD);
        check("ovr_accepted",   acc_q.size() - b_q, 1);
        check("ovr_first_byte", last_byte(), 8'h00);
        check("hold_stable",    n_hold_viol, 0);

        // false start
        snap();
        u_if.rx = 1'b0;
        cyc(5);
        u_if.rx = 1'b1;
        cyc(14);
        check("false_busy_seen", int'((n_busy - b_b) > 0), 1);
        check("false_busy_end",  int'(u_if.busy), 0);
        check("false_no_byte",   acc_q.size() - b_q, 0);

        // break: stop low, then line held low 40 bit times
        snap();
        send_frame(8'h3C, 1'b0);
        u_if.rx = 1'b0;
        cyc(40 * BD);
        u_if.rx = 1'b1;
        cyc(2 * BD);
        check("break_ferr",    n_ferr - b_f, 1);
        check("break_no_byte", acc_q.size() - b_q, 0);
        check("break_idle",    int'(u_if.busy), 0);
        send_frame(8'h81, 1'b1);
        u_if.rx = 1'b1;
        cyc(2 * BD);
        check("after_break_n",    acc_q.size() - b_q, 1);
        check("after_break_data", last_byte(), 8'h81);

        // reset in the middle of 0x55
        snap();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        cyc(1);
        check("rst_mid_data",  int'(u_if.data), 0);
        check("rst_mid_valid", int'(u_if.valid), 0);
        check("rst_mid_busy",  int'(u_if.busy), 0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b1);
        u_if.rx = 1'b1;
        cyc(BD);
        rst = 1'b0;
        cyc(2 * BD);
        check("rst_no_partial", acc_q.size() - b_q, 0);
        send_frame(8'h12, 1'b1);
        u_if.rx = 1'b1;
        cyc(2 * BD);
        check("rst_then_n",    acc_q.size() - b_q, 1);
        check("rst_then_data", last_byte(), 8'h12);

`ifdef UART_RX_PARITY_EN
        begin
            int b_p;
            snap();
            b_p = n_perr;
            par_flip = 1'b0;
            send_frame(8'h07, 1'b1);
            u_if.rx = 1'b1;
            cyc(2 * BD);
            check("par_good_n",    acc_q.size() - b_q, 1);
            check("par_good_data", last_byte(), 8'h07);
            check("par_good_perr", n_perr - b_p, 0);
            snap();
            par_flip = 1'b1;
            send_frame(8'h07, 1'b1);
            par_flip = 1'b0;
            u_if.rx = 1'b1;
            cyc(2 * BD);
            check("par_bad_perr", n_perr - b_p, 1);
            check("par_bad_n",    acc_q.size() - b_q, 0);
            check("par_bad_ferr", n_ferr - b_f, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
